matrix_exec_unit: RTL and testbench

MATRIX_EXEC_UNIT -- requirements
Module: matrix_exec_unit

---
 rtl/matrix_exec_unit_pkg.sv | 8 +
 rtl/CONSTANT.v | 10 +
 rtl/matrix_exec_unit_dot.sv | 13 +
 rtl/matrix_exec_unit.sv | 86 ++++++++
 tb/tb_matrix_exec_unit.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/matrix_exec_unit_pkg.sv
// matrix_exec_unit_pkg: FSM state type and the element-wise operator.
`include "CONSTANT.v"
package matrix_exec_unit_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  function automatic logic [31:0] elem_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op == `OP_SUB) ? a - b : (op == `OP_EMUL) ? a * b : a + b;
  endfunction
endpackage

// File: rtl/CONSTANT.v
// CONSTANT: global dimensions and op encodings shared by the matrix unit.
`ifndef CONSTANT_V
`define CONSTANT_V
`define WIDTH_BIT 2
`define INDEX_BIT 3
`define OP_ADD 2'b00
`define OP_SUB 2'b01
`define OP_MATMUL 2'b10
`define OP_EMUL 2'b11
`endif

// File: rtl/matrix_exec_unit_dot.sv
// matrix_dot: WIDTH-lane 32-bit wrapping dot product of one row and one column.
module matrix_dot #(
  parameter int WIDTH = 4
) (
  input  logic [0:WIDTH-1][31:0] row_i,
  input  logic [0:WIDTH-1][31:0] col_i,
  output logic [31:0]            sum_o
);
  always_comb begin
    sum_o = '0;
    for (int m = 0; m < WIDTH; m++) sum_o = sum_o + row_i[m] * col_i[m];
  end
endmodule

// File: rtl/matrix_exec_unit.sv
// matrix_exec_unit: latches two matrices and computes ADD/SUB/EMUL in one cycle
// or MATMUL one element per cycle, then strobes a register-file writeback.
`include "CONSTANT.v"
module matrix_exec_unit
  import matrix_exec_unit_pkg::*;
#(
  parameter int WIDTH = 2 ** `WIDTH_BIT
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             start,
  input  logic [1:0]                       op,
  input  logic [`INDEX_BIT-1:0]            dst,
  input  logic [0:WIDTH-1][0:WIDTH-1][31:0] op_a,
  input  logic [0:WIDTH-1][0:WIDTH-1][31:0] op_b,
  output logic                             busy,
  output logic                             done,
  output logic                             wb_enable,
  output logic [`INDEX_BIT-1:0]            wb_index,
  output logic [0:WIDTH-1][0:WIDTH-1][31:0] result
);
  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH * WIDTH) : 1;
  localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] WK = KW'(WIDTH);
  localparam logic [KW-1:0] LAST = KW'(WIDTH * WIDTH - 1);
  state_e                             state_q;
  logic [KW-1:0]                      k_q;
  logic [1:0]                         op_q;
  logic [`INDEX_BIT-1:0]              dst_q;
  logic [0:WIDTH-1][0:WIDTH-1][31:0]  a_q, b_q, result_q, elem;
  logic [0:WIDTH-1][31:0]             col_v;
  logic [RW-1:0]                      row, col;
  logic [31:0]                        dot;
  always_comb begin
    row = RW'(k_q / WK);
    col = RW'(k_q % WK);
  end
  always_comb begin
    col_v = '0;
    elem = '0;
    for (int i = 0; i < WIDTH; i++) begin
      col_v[i] = b_q[i][col];
      for (int j = 0; j < WIDTH; j++) elem[i][j] = elem_op(op_q, a_q[i][j], b_q[i][j]);
    end
  end
  // One shared dot-product lane; k walks it across the result row-major.
  matrix_dot #(.WIDTH(WIDTH)) u_dot (.row_i(a_q[row]), .col_i(col_v), .sum_o(dot));
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      k_q      <= '0;
      op_q     <= '0;
      dst_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q      <= op_a;
          b_q      <= op_b;
          op_q     <= op;
          dst_q    <= dst;
          result_q <= '0;
          k_q      <= '0;
          state_q  <= CALC;
        end
        CALC: if (op_q == `OP_MATMUL) begin
          result_q[row][col] <= dot;
          k_q                <= k_q + 1'b1;
          if (k_q == LAST) state_q <= DONE;
        end else begin
          result_q <= elem;
          state_q  <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign wb_enable = done;
  assign wb_index  = dst_q;
  assign result    = result_q;
endmodule

// File: tb/tb_matrix_exec_unit.sv
// tb_matrix_exec_unit: directed tests of the 4x4 matrix execution unit.
module tb_matrix_exec_unit;
  typedef logic [0:3][0:3][31:0] mat_t;
  logic       CLK, RST_N, start, busy, done, wb_enable;
  logic [1:0] op;
  logic [2:0] dst, wb_index;
  mat_t       op_a, op_b, result;
  int         checks = 0;
  int         errors = 0;

  matrix_exec_unit #(.WIDTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .op(op), .dst(dst),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .wb_enable(wb_enable), .wb_index(wb_index), .result(result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic mat_t diag(input logic [31:0] v);
    mat_t m = '0;
    for (int i = 0; i < 4; i++) m[i][i] = v;
    return m;
  endfunction

  function automatic mat_t fill(input logic [31:0] v);
    mat_t m;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic mat_t seq16();
    mat_t m;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = 32'(i * 4 + j + 1);
    return m;
  endfunction

  // Issues one start, scrambles the operand buses after the accept edge,
  // optionally re-asserts start (with dst=6) at cycles inj1/inj2, and
  // records the done/busy/wb_enable profile over 20 cycles.
  task automatic run_op(input logic [1:0] o, input logic [2:0] d, input int inj1, input int inj2,
                        output int done_at, output int done_cnt, output int busy_cnt, output int we_cnt);
    start = 1'b1; op = o; dst = d;
    @(posedge CLK); #1;
    start = 1'b0;
    op_a = ~op_a;
    op_b = ~op_b;
    done_at = -1; done_cnt = 0; busy_cnt = 0; we_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) busy_cnt++;
      if (wb_enable) we_cnt++;
      if (done) begin done_cnt++; done_at = c - 1; end
      start = (c == inj1) || (c == inj2);
      dst = start ? 3'd6 : d;
      op = start ? 2'b00 : o;
      @(posedge CLK); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; start = 1'b0; op = '0; dst = '0; op_a = '0; op_b = '0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0 || wb_enable !== 1'b0) begin errors++; $display("FAIL reset_done got=%b%b exp=00", done, wb_enable); end
    checks++; if (wb_index !== 3'd0) begin errors++; $display("FAIL reset_wb_index got=%0d exp=0", wb_index); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    @(posedge CLK); #1;
    RST_N = 1'b1;
  endtask

  task automatic test_add();
    int da, dc, bc, wc;
    op_a = diag(32'd1); op_b = diag(32'd1);
    run_op(2'b00, 3'd5, 0, 0, da, dc, bc, wc);
    checks++; if (result !== diag(32'd2)) begin errors++; $display("FAIL add_result got=%h exp=%h", result, diag(32'd2)); end
    checks++; if (da !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", da); end
    checks++; if (dc !== 1 || wc !== 1) begin errors++; $display("FAIL add_done_pulses got=%0d/%0d exp=1/1", dc, wc); end
    checks++; if (bc !== 2) begin errors++; $display("FAIL add_busy_cycles got=%0d exp=2", bc); end
    checks++; if (wb_index !== 3'd5) begin errors++; $display("FAIL add_wb_index got=%0d exp=5", wb_index); end
  endtask

  task automatic test_sub_wrap();
    int da, dc, bc, wc;
    op_a = '0; op_b = fill(32'd1);
    run_op(2'b01, 3'd1, 0, 0, da, dc, bc, wc);
    checks++; if (result !== fill(32'hFFFF_FFFF)) begin errors++; $display("FAIL sub_result got=%h exp=all_ffffffff", result); end
    checks++; if (da !== 1 || dc !== 1) begin errors++; $display("FAIL sub_done got=%0d/%0d exp=1/1", da, dc); end
  endtask

  task automatic test_matmul();
    int da, dc, bc, wc;
    op_a = seq16(); op_b = diag(32'd1);
    run_op(2'b10, 3'd4, 0, 0, da, dc, bc, wc);
    checks++; if (result !== seq16()) begin errors++; $display("FAIL matmul_result got=%h exp=%h", result, seq16()); end
    checks++; if (da !== 16) begin errors++; $display("FAIL matmul_latency got=%0d exp=16", da); end
    checks++; if (bc !== 17) begin errors++; $display("FAIL matmul_busy_cycles got=%0d exp=17", bc); end
    checks++; if (dc !== 1 || wc !== 1) begin errors++; $display("FAIL matmul_done_pulses got=%0d/%0d exp=1/1", dc, wc); end
    checks++; if (wb_index !== 3'd4) begin errors++; $display("FAIL matmul_wb_index got=%0d exp=4", wb_index); end
  endtask

  task automatic test_overflow();
    int da, dc, bc, wc;
    op_a = fill(32'h0001_0000); op_b = fill(32'h0001_0000);
    run_op(2'b11, 3'd2, 0, 0, da, dc, bc, wc);
    checks++; if (result !== '0) begin errors++; $display("FAIL emul_overflow got=%h exp=0", result); end
    op_a = fill(32'h0001_0000); op_b = fill(32'h0001_0000);
    run_op(2'b10, 3'd3, 0, 0, da, dc, bc, wc);
    checks++; if (result !== '0) begin errors++; $display("FAIL matmul_overflow got=%h exp=0", result); end
    checks++; if (da !== 16) begin errors++; $display("FAIL matmul_overflow_latency got=%0d exp=16", da); end
  endtask

  task automatic test_start_while_busy();
    int da, dc, bc, wc;
    op_a = seq16(); op_b = diag(32'd1);
    // Extra starts land 3 cycles into CALC and during the DONE cycle.
    run_op(2'b10, 3'd2, 4, 17, da, dc, bc, wc);
    checks++; if (dc !== 1) begin errors++; $display("FAIL busy_ignore_done_count got=%0d exp=1", dc); end
    checks++; if (da !== 16) begin errors++; $display("FAIL busy_ignore_latency got=%0d exp=16", da); end
    checks++; if (bc !== 17) begin errors++; $display("FAIL busy_ignore_busy_cycles got=%0d exp=17", bc); end
    checks++; if (wb_index !== 3'd2) begin errors++; $display("FAIL busy_ignore_wb_index got=%0d exp=2", wb_index); end
    checks++; if (result !== seq16()) begin errors++; $display("FAIL busy_ignore_result got=%h exp=%h", result, seq16()); end
  endtask

  task automatic test_reset_mid();
    int dc = 0;
    int da, dc2, bc, wc;
    op_a = seq16(); op_b = diag(32'd1);
    start = 1'b1; op = 2'b10; dst = 3'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) begin
      if (done || wb_enable) dc++;
      @(posedge CLK); #1;
    end
    RST_N = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || wb_enable !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got=%b%b%b exp=000", busy, done, wb_enable); end
    checks++; if (wb_index !== 3'd0) begin errors++; $display("FAIL midreset_wb_index got=%0d exp=0", wb_index); end
    checks++; if (result !== '0) begin errors++; $display("FAIL midreset_result got=%h exp=0", result); end
    repeat (3) begin
      @(posedge CLK); #1;
      if (done || wb_enable) dc++;
    end
    checks++; if (dc !== 0) begin errors++; $display("FAIL midreset_no_done got=%0d exp=0", dc); end
    RST_N = 1'b1;
    op_a = diag(32'd1); op_b = diag(32'd1);
    run_op(2'b00, 3'd7, 0, 0, da, dc2, bc, wc);
    checks++; if (result !== diag(32'd2) || da !== 1) begin errors++; $display("FAIL postreset_add got=%h/%0d exp=%h/1", result, da, diag(32'd2)); end
    checks++; if (wb_index !== 3'd7) begin errors++; $display("FAIL postreset_wb_index got=%0d exp=7", wb_index); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_matmul();
    test_overflow();
    test_start_while_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
